// File: rtl/bcd_pkg.sv
// bcd_pkg
// Types, constants and helpers for 8421 BCD decade logic. Imported by
// bcd_digit (one decade cell) and bcd_updown_counter (multi-digit top).
//   bcd_digit_t : one BCD digit, 4 bits
//   BCD_MAX     : largest legal digit value (9)
//   BCD_MIN     : smallest legal digit value (0)
//   is_bcd()    : 1 when a 4-bit value is a legal decimal digit
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic is_bcd(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// A single 4-bit decade cell. It steps up (9 -> 0) or down (0 -> 9) when
// step is high. Clear and load take priority over step. A non-BCD load
// value is replaced by 0, so the cell never holds a code above 9.
// Ports:
//   CLK   in  : clock, rising edge
//   Reset in  : asynchronous active-high reset, forces q to 0
//   clr   in  : synchronous clear (highest synchronous priority)
//   load  in  : synchronous load of d
//   d     in  : load value (4 bits)
//   step  in  : advance by one in the direction given by up
//   up    in  : 1 = increment, 0 = decrement
//   q     out : current digit
//   is9   out : q == 9 (carry-propagate flag for higher digits)
//   is0   out : q == 0 (borrow-propagate flag for higher digits)
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t d,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t q,
    output logic       is9,
    output logic       is0
);

    bcd_digit_t q_q;
    bcd_digit_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = BCD_MIN;
        end else if (load) begin
            q_d = is_bcd(d) ? d : BCD_MIN;
        end else if (step) begin
            if (up) begin
                q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
            end else begin
                q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign is9 = (q_q == BCD_MAX);
    assign is0 = (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
// Multi-digit synchronous 8421 BCD up/down counter. All digits share one
// clock. Carries and borrows ripple combinationally through the digits'
// is9/is0 flags, so every digit updates on the same edge.
// Parameters:
//   DIGITS : number of BCD digits (1..8), range 0 .. 10^DIGITS-1
// Ports:
//   CLK      in  : clock, rising edge
//   Reset    in  : asynchronous active-high reset
//   clr      in  : synchronous clear of Q, wrap and bad_load
//   load     in  : synchronous parallel load from din (wins over en)
//   en       in  : count enable
//   up       in  : direction, 1 = increment, 0 = decrement
//   din      in  : load value, digit i at [4i+3:4i]
//   Q        out : current count, same packing as din
//   tc       out : combinational terminal count, drives a cascaded en
//   wrap     out : sticky wrap-around flag
//   bad_load out : one-cycle flag after a load containing a non-BCD digit
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  en,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  bad_load
);

    // all9_below[i] / all0_below[i]: every digit below i is 9 / 0.
    // Index DIGITS covers the whole counter and feeds tc.
    logic [DIGITS:0]   all9_below;
    logic [DIGITS:0]   all0_below;
    logic [DIGITS-1:0] is9;
    logic [DIGITS-1:0] is0;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] digit_ok;

    logic wrap_q;
    logic wrap_d;
    logic bad_load_q;
    logic bad_load_d;

    assign all9_below[0] = 1'b1;
    assign all0_below[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign all9_below[gi+1] = all9_below[gi] & is9[gi];
            assign all0_below[gi+1] = all0_below[gi] & is0[gi];
            assign step[gi]         = en & (up ? all9_below[gi] : all0_below[gi]);
            assign digit_ok[gi]     = is_bcd(din[4*gi +: 4]);

            bcd_digit u_digit (
                .CLK   (CLK),
                .Reset (Reset),
                .clr   (clr),
                .load  (load),
                .d     (din[4*gi +: 4]),
                .step  (step[gi]),
                .up    (up),
                .q     (Q[4*gi +: 4]),
                .is9   (is9[gi]),
                .is0   (is0[gi])
            );
        end
    endgenerate

    assign tc = en & (up ? all9_below[DIGITS] : all0_below[DIGITS]);

    // tc already includes en, so with no clr/load a high tc means this edge
    // counts across the boundary.
    always_comb begin
        wrap_d = wrap_q;
        if (clr || load) begin
            wrap_d = 1'b0;
        end else if (tc) begin
            wrap_d = 1'b1;
        end
    end

    assign bad_load_d = ~clr & load & ~(&digit_ok);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wrap_q     <= 1'b0;
            bad_load_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            bad_load_q <= bad_load_d;
        end
    end

    assign wrap     = wrap_q;
    assign bad_load = bad_load_q;

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit synchronous 8421 BCD up/down counter with parallel load, enable, synchronous clear, cascade terminal-count output and a sticky wrap flag. It is the next-generation decade counter for the experiment designs. All digit registers share one clock edge, with no rippled clocks. It drives the display/decoder blocks and cascades into further counters via `tc`.

## Interface
- `DIGITS`, default 2: number of BCD digits (1..8); counting range 0 .. 10^DIGITS-1.
- `CLK`  input  1: clock; all state updates on the rising edge.
- `Reset`  input  1: asynchronous, active-high reset.
- `clr`  input  1: synchronous clear to all-zero.
- `load`  input  1: synchronous parallel load from `din`.
- `en`  input  1: count enable.
- `up`  input  1: direction; 1 = increment, 0 = decrement.
- `din`  input  4*DIGITS: load value; digit i at bits [4i+3:4i], digit 0 least significant.
- `Q`  output  4*DIGITS: current count, same digit packing as `din`.
- `tc`  output  1: combinational terminal count (see Operation).
- `wrap`  output  1: sticky flag, set on any wrap-around.
- `bad_load`  output  1: registered; high for one cycle after a load that contained a non-BCD digit.

## Operation
- Reset (async, highest priority): `Q`=0, `wrap`=0, `bad_load`=0 immediately, independent of `CLK`.
- Priority per rising edge: `clr` > `load` > `en` > hold.
- `clr`:
  - `Q`=0, `wrap`=0, `bad_load`=0.
- `load`:
  - Each digit of `din` is copied into `Q`.
  - Any digit > 9 (A..F) is loaded as 0 instead, and `bad_load`=1 for that cycle.
  - `wrap` is cleared.
  - `bad_load` is 0 after any non-load edge.
- Count (`en`=1, `up`=1):
  - Digit 0 increments.
  - Digit i increments when all lower digits equal 9; a digit at 9 that increments becomes 0.
  - All digits update in the same edge, with the carry computed combinationally.
- Count (`en`=1, `up`=0):
  - Digit i decrements when all lower digits equal 0.
  - A digit at 0 that decrements becomes 9.
- `tc` = `en` & ((`up` & all digits 9) | (~`up` & all digits 0)). It is asserted in the cycle before the wrap edge.
- `wrap` is set on the edge where `tc`=1 and count occurs. It stays set until `clr`, `load` or `Reset`.
- The counter never holds a non-BCD digit in any state.
- `en`=0: `Q` and `wrap` hold. `up` may change freely.

## Timing
- Count and load latency: 1 cycle (the new `Q` is visible after the edge).
- `tc` is purely combinational from `Q`, `en` and `up`, in the same cycle. It is intended for the next stage's `en`, so cascaded counters stay synchronous on the shared `CLK`.
- Simultaneous `load` and `en`: load wins and no count occurs. Simultaneous `clr` and `load`: clear wins.
- Direction reversal at a boundary:
  - `Q`=0 with `up`=1 counts to 1, with no `wrap`.
  - `Q`=0 with `up`=0 wraps to all-9 and sets `wrap`.
- `Reset` asserted mid-count forces zero asynchronously. After deassertion the first rising edge acts on the inputs normally.

## Structure
- Shared package `bcd_pkg` holds:
  - `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0.
  - The typedef `bcd_digit_t` (logic [3:0]).
  - The function `is_bcd(digit)`.
- One sub-module, `bcd_digit`, is natural: a single 4-bit decade cell.
  - Inputs: `CLK`, `Reset`, `clr`, `load`, `d`, `step`, `up`.
  - Outputs: `q`, plus `is9` and `is0` flags.
  - `DIGITS` instances are generated. The top level builds the step-enable chain from the lower digits' `is9`/`is0` flags and derives `tc`.

## Test plan
- Reset with `DIGITS`=2: assert `Reset` between edges → `Q`=8'h00, `wrap`=0 without a clock edge; release, `en`=1, `up`=1, 3 edges → `Q`=8'h03.
- Up carry: load 8'h19, count up 1 → 8'h20; load 8'h98, count → `tc`=0 at 98, `tc`=1 at 99, next edge → 8'h00 and `wrap`=1.
- Down borrow: load 8'h10, `up`=0, count → 8'h09; load 8'h00, `up`=0 → `tc`=1, next edge → 8'h99 and `wrap`=1.
- Illegal load: `din`=8'h3C → `Q`=8'h30, `bad_load`=1 for one cycle then 0; `din`=8'hFF → `Q`=8'h00.
- Priority: `clr`, `load` (8'h55) and `en` all high → `Q`=8'h00; `load`+`en` with `din`=8'h55 → `Q`=8'h55 (no increment).
- Cascade: two `DIGITS`=1 instances, the second's `en` tied to the first's `tc`, 100 edges from 0 → combined count returns to 0 with no non-BCD value ever observed.
